// File: rtl/cond_unit.sv
// ARM-style conditional execution unit: evaluates the condition field against
// the architectural flags, latches the verdict, and gates PC/register/memory/flag writes.

module cond_check (
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);
  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    pass = 1'b0;
    case (cond)
      4'b0000: pass = z;
      4'b0001: pass = ~z;
      4'b0010: pass = c;
      4'b0011: pass = ~c;
      4'b0100: pass = n;
      4'b0101: pass = ~n;
      4'b0110: pass = v;
      4'b0111: pass = ~v;
      4'b1000: pass = c & ~z;
      4'b1001: pass = ~c | z;
      4'b1010: pass = ~(n ^ v);
      4'b1011: pass = n ^ v;
      4'b1100: pass = ~z & ~(n ^ v);
      4'b1101: pass = z | (n ^ v);
      4'b1110: pass = 1'b1;
      default: pass = 1'b0;  // 1111 is reserved: never execute
    endcase
  end
endmodule

module cond_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       EvalEn,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags
);
  logic cond_eval;
  logic cond_ex_r;

  // Evaluation always uses the registered flags, so a flag write in the same
  // cycle only affects the next evaluation.
  cond_check u_check (
    .cond  (Cond),
    .flags (Flags),
    .pass  (cond_eval)
  );

  // Outside the evaluation strobe, the latched verdict keeps gating the
  // remaining phases of a multicycle instruction.
  assign CondEx   = EvalEn ? cond_eval : cond_ex_r;
  assign PCSrc    = PCS  & CondEx;
  assign RegWrite = RegW & CondEx & ~NoWrite;
  assign MemWrite = MemW & CondEx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      cond_ex_r <= 1'b0;
    else if (EvalEn) cond_ex_r <= cond_eval;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Flags <= 4'b0000;
    end else begin
      if (FlagW[1] & CondEx) Flags[3:2] <= ALUFlags[3:2];
      if (FlagW[0] & CondEx) Flags[1:0] <= ALUFlags[1:0];
    end
  end
endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit: spec-level model compared every cycle, plus
// hand-computed literal expectations for the key scenarios and a full Cond x Flags sweep.

module tb_cond_unit;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] Cond = 4'd0, ALUFlags = 4'd0;
  logic [1:0] FlagW = 2'd0;
  logic       EvalEn = 1'b0, PCS = 1'b0, RegW = 1'b0, MemW = 1'b0, NoWrite = 1'b0;
  logic       PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0] Flags;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cond_unit dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .EvalEn(EvalEn), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
    .Flags(Flags)
  );

  // Conditions come in complementary pairs: the odd code negates the even one.
  function automatic logic spec_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  // Architectural model state
  logic [3:0] m_flags;
  logic       m_verdict;
  logic       e_cex;
  assign e_cex = EvalEn ? spec_cond(Cond, m_flags) : m_verdict;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_flags   <= 4'd0;
      m_verdict <= 1'b0;
    end else begin
      if (EvalEn) m_verdict <= spec_cond(Cond, m_flags);
      m_flags <= { (FlagW[1] && e_cex) ? ALUFlags[3:2] : m_flags[3:2],
                   (FlagW[0] && e_cex) ? ALUFlags[1:0] : m_flags[1:0] };
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("cmp_CondEx",   {31'd0, CondEx},   {31'd0, e_cex});
    chk("cmp_PCSrc",    {31'd0, PCSrc},    {31'd0, PCS & e_cex});
    chk("cmp_RegWrite", {31'd0, RegWrite}, {31'd0, RegW & e_cex & !NoWrite});
    chk("cmp_MemWrite", {31'd0, MemWrite}, {31'd0, MemW & e_cex});
    chk("cmp_Flags",    {28'd0, Flags},    {28'd0, m_flags});
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    EvalEn = 0; FlagW = 0; PCS = 0; RegW = 0; MemW = 0; NoWrite = 0; Cond = 0; ALUFlags = 0;
  endtask

  // Load flags through an always-true evaluation
  task automatic set_flags(input logic [3:0] f);
    Cond = 4'b1110; EvalEn = 1; FlagW = 2'b11; ALUFlags = f;
    cyc();
    FlagW = 2'b00;
  endtask

  typedef struct { logic [3:0] f; logic [3:0] c; logic exp; } vec_t;
  vec_t vecs[8];

  initial begin
    vecs[0] = '{4'b0000, 4'b1100, 1'b1};  // GT, Z=0 N==V
    vecs[1] = '{4'b0010, 4'b1000, 1'b1};  // HI, C=1 Z=0
    vecs[2] = '{4'b0110, 4'b1000, 1'b0};  // HI, Z=1
    vecs[3] = '{4'b0110, 4'b1001, 1'b1};  // LS
    vecs[4] = '{4'b1001, 4'b1010, 1'b1};  // GE, N=V=1
    vecs[5] = '{4'b1000, 4'b1101, 1'b1};  // LE, N!=V
    vecs[6] = '{4'b0001, 4'b0110, 1'b1};  // VS
    vecs[7] = '{4'b1111, 4'b1111, 1'b0};  // NV

    #2 reset = 1'b0;
    repeat (2) cyc();
    chk("reset_Flags",  {28'd0, Flags}, 32'h0);
    chk("reset_CondEx", {31'd0, CondEx}, 32'h0);
    reset = 1'b1;

    // AL with flag write
    Cond = 4'b1110; EvalEn = 1; FlagW = 2'b11; ALUFlags = 4'b0100; #1;
    chk("al_CondEx", {31'd0, CondEx}, 32'h1);
    cyc();
    chk("al_Flags", {28'd0, Flags}, 32'h4);
    FlagW = 0;

    // EQ passes with Z=1, NE blocks all writes
    Cond = 4'b0000; RegW = 1; MemW = 1; NoWrite = 0; #1;
    chk("eq_CondEx", {31'd0, CondEx}, 32'h1);
    chk("eq_RegWrite", {31'd0, RegWrite}, 32'h1);
    chk("eq_MemWrite", {31'd0, MemWrite}, 32'h1);
    NoWrite = 1; #1;
    chk("eq_NoWrite_RegWrite", {31'd0, RegWrite}, 32'h0);
    NoWrite = 0; Cond = 4'b0001; #1;
    chk("ne_CondEx", {31'd0, CondEx}, 32'h0);
    chk("ne_RegWrite", {31'd0, RegWrite}, 32'h0);
    chk("ne_MemWrite", {31'd0, MemWrite}, 32'h0);
    cyc();
    idle();

    // LT latched verdict carries through multicycle phases
    set_flags(4'b1000);
    Cond = 4'b1011; EvalEn = 1; PCS = 1; #1;
    chk("lt_PCSrc_0", {31'd0, PCSrc}, 32'h1);
    cyc();
    EvalEn = 0; Cond = 4'b0000; #1;
    chk("lt_PCSrc_1", {31'd0, PCSrc}, 32'h1);
    cyc();
    chk("lt_PCSrc_2", {31'd0, PCSrc}, 32'h1);
    cyc();
    idle();

    // Independent flag halves
    set_flags(4'b0000);
    FlagW = 2'b10; ALUFlags = 4'b1111;
    cyc();
    chk("half_NZ_Flags", {28'd0, Flags}, 32'hC);
    FlagW = 2'b01; ALUFlags = 4'b0011;
    cyc();
    chk("half_CV_Flags", {28'd0, Flags}, 32'hF);

    // Same-edge eval and flag write: verdict uses old flags
    Cond = 4'b0000; EvalEn = 1; FlagW = 2'b11; ALUFlags = 4'b0000; #1;
    chk("pre_edge_CondEx", {31'd0, CondEx}, 32'h1);
    cyc();
    FlagW = 0; #1;
    chk("post_edge_CondEx", {31'd0, CondEx}, 32'h0);
    cyc();
    idle();

    // NV blocks everything including flags; then async reset mid-cycle
    set_flags(4'b1010);
    Cond = 4'b1111; EvalEn = 1; FlagW = 2'b11; ALUFlags = 4'b1111; RegW = 1; #1;
    chk("nv_CondEx", {31'd0, CondEx}, 32'h0);
    chk("nv_RegWrite", {31'd0, RegWrite}, 32'h0);
    cyc();
    chk("nv_Flags", {28'd0, Flags}, 32'hA);
    Cond = 4'b1110; FlagW = 2'b00;
    cyc();
    EvalEn = 0; Cond = 4'b1111; FlagW = 2'b11; #1;
    chk("latched_CondEx", {31'd0, CondEx}, 32'h1);
    #1 reset = 1'b0; #1;
    chk("async_rst_Flags", {28'd0, Flags}, 32'h0);
    chk("async_rst_CondEx", {31'd0, CondEx}, 32'h0);
    chk("async_rst_RegWrite", {31'd0, RegWrite}, 32'h0);
    cyc();
    reset = 1'b1;
    cyc();
    chk("release_Flags", {28'd0, Flags}, 32'h0);
    idle();

    // Full sweep; the compare process checks every cycle, plus direct checks here
    for (int f = 0; f < 16; f++) begin
      set_flags(4'(f));
      for (int c = 0; c < 16; c++) begin
        Cond = 4'(c); EvalEn = 1; #1;
        chk("sweep_CondEx", {31'd0, CondEx}, {31'd0, spec_cond(4'(c), 4'(f))});
        cyc();
      end
    end

    // Hand-computed table rows pin the model itself
    foreach (vecs[i]) begin
      set_flags(vecs[i].f);
      Cond = vecs[i].c; EvalEn = 1; #1;
      chk("table_CondEx", {31'd0, CondEx}, {31'd0, vecs[i].exp});
      cyc();
    end

    idle();
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cond_unit.md
COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; there are no parameters.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous active-low reset (0 = reset asserted).
REQ-004 Cond  input  4  ARM condition field of the current instruction.
REQ-005 ALUFlags  input  4  ALU flags {N,Z,C,V} of the current operation.
REQ-006 FlagW  input  2  flag-write request: bit1 = N,Z; bit0 = C,V.
REQ-007 EvalEn  input  1  execute-phase strobe: evaluate Cond and latch the verdict.
REQ-008 PCS, RegW, MemW  input  1 each  decoder write requests: PC, register file, memory.
REQ-009 NoWrite  input  1  compare-class instruction: suppress the register write.
REQ-010 PCSrc, RegWrite, MemWrite  output  1 each  gated write enables.
REQ-011 CondEx  output  1  effective condition verdict for the current cycle.
REQ-012 Flags  output  4  architectural flag register {N,Z,C,V}.

Function
REQ-013 Flags SHALL be a 4-bit register; CondExR SHALL be a 1-bit register holding the last latched verdict.
REQ-014 CondEval SHALL be combinational from Cond and the registered Flags, never from ALUFlags:
- 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C
- 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
- 1000 HI C&!Z; 1001 LS !C|Z
- 1010 GE N==V; 1011 LT N!=V
- 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
- 1110 AL 1; 1111 SHALL evaluate to 0 (never).
REQ-015 CondEx SHALL equal CondEval when EvalEn=1, and CondExR otherwise.
REQ-016 On each rising edge with EvalEn=1, CondExR SHALL load CondEval; with EvalEn=0, it SHALL hold.
REQ-017 PCSrc SHALL equal PCS & CondEx.
REQ-018 RegWrite SHALL equal RegW & CondEx & !NoWrite.
REQ-019 MemWrite SHALL equal MemW & CondEx.
REQ-020 On a rising edge with FlagW[1] & CondEx, Flags[3:2] SHALL load ALUFlags[3:2]; otherwise they SHALL hold.
REQ-021 On a rising edge with FlagW[0] & CondEx, Flags[1:0] SHALL load ALUFlags[1:0]; otherwise they SHALL hold.
REQ-022 The two halves of Flags SHALL update independently; FlagW=2'b10 SHALL leave C,V unchanged.
REQ-023 Simultaneous EvalEn and flag write: the verdict SHALL use pre-edge Flags; the new flags SHALL be visible from the next cycle only.
REQ-024 Latency: the verdict SHALL be available in the same cycle as EvalEn; flag updates SHALL take effect one cycle after the edge.
REQ-025 A verdict latched in CondExR SHALL gate all writes in subsequent multicycle phases until the next EvalEn.

Reset
REQ-026 While reset=0, Flags SHALL be 4'b0000 and CondExR SHALL be 0, asynchronously and independent of clk.
REQ-027 During and after reset with EvalEn=0, CondEx, PCSrc, RegWrite and MemWrite SHALL be 0.
REQ-028 Assertion of reset mid-instruction SHALL discard the latched verdict and any pending flag write.
REQ-029 Deassertion of reset SHALL take effect at the first rising edge after release; no flag or verdict update SHALL occur on that release.

Verification
REQ-030 Reset, then Cond=1110, EvalEn=1, FlagW=11, ALUFlags=0100 -> CondEx=1; after the edge, Flags=0100.
REQ-031 With Flags=0100, Cond=0000, EvalEn=1, RegW=1, MemW=1, NoWrite=0 -> CondEx=1, RegWrite=1, MemWrite=1; with Cond=0001 -> all writes 0.
REQ-032 With Flags=1000, Cond=1011 (LT), EvalEn=1, then EvalEn=0 for 2 cycles with PCS=1 -> PCSrc=1 in all 3 cycles.
REQ-033 With Flags=0000, FlagW=10, ALUFlags=1111, Cond=1110 -> Flags=1100 after the edge (C,V held).
REQ-034 Cond=1111, FlagW=11, ALUFlags=1111, RegW=1 -> CondEx=0, RegWrite=0, Flags unchanged; then reset pulse mid-cycle -> Flags=0000 and CondEx=0 immediately.
REQ-035 Sweep all 16 Cond values against all 16 Flags values with EvalEn=1 -> CondEx matches the REQ-014 table in all 256 cases.
